reg_bank8: RTL

- Eight-entry general-purpose register bank for the microprocessor datapath.
- Sits directly downstream of the 3-to-8 register-select decoder and consumes its one-hot output as the per-register write strobe.
- Provides two synchronous read ports for ALU operands, with write-to-read bypass and a sticky error flag for malformed strobes.

---
 rtl/reg_bank8_pkg.sv | 36 +++
 rtl/reg_bank8_onehot_chk.sv | 27 ++
 rtl/reg_bank8.sv | 82 ++++++++
 3 files changed

// File: rtl/reg_bank8_pkg.sv
// Shared definitions for the register bank: sizes, write classification
// and the one-hot checking helpers reused by other strobe consumers.
package reg_bank8_pkg;

    localparam int unsigned NREGS   = 8;
    localparam int unsigned RADDR_W = 3;
    localparam int unsigned CNT_W   = $clog2(NREGS + 1);

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_VALID   = 2'd1,
        WR_INVALID = 2'd2
    } wr_class_e;

    // Number of set bits in a strobe vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    function automatic wr_class_e wr_classify(input logic [NREGS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = popcount(v);
        if (cnt == '0) begin
            return WR_IDLE;
        end else if (cnt == CNT_W'(1)) begin
            return WR_VALID;
        end
        return WR_INVALID;
    endfunction

endpackage

// File: rtl/reg_bank8_onehot_chk.sv
// Classifies the decoder strobe and encodes the index of its set bit.
module onehot_chk
    import reg_bank8_pkg::*;
(
    input  logic [NREGS-1:0]   we,
    output logic               valid,
    output logic               multi,
    output logic [RADDR_W-1:0] idx
);

    wr_class_e wr_class;

    assign wr_class = wr_classify(we);
    assign valid    = (wr_class == WR_VALID);
    assign multi    = (wr_class == WR_INVALID);

    // Index is only meaningful when valid is set.
    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (we[i]) begin
                idx = RADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/reg_bank8.sv
// Eight-entry register bank with one-hot write strobe, two registered
// read ports with write bypass, and a sticky malformed-strobe flag.
module reg_bank8
    import reg_bank8_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ZERO_REG = 0
)(
    input  logic               clk,
    input  logic               nrst,
    input  logic [NREGS-1:0]   we,
    input  logic [WIDTH-1:0]   wd,
    input  logic [RADDR_W-1:0] ra,
    input  logic [RADDR_W-1:0] rb,
    input  logic               hold,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   rda,
    output logic [WIDTH-1:0]   rdb,
    output logic               wack,
    output logic               err
);

    logic [WIDTH-1:0]   regs [NREGS];
    logic               wr_valid;
    logic               wr_multi;
    logic [RADDR_W-1:0] wr_idx;
    logic               wr_commit;
    logic [WIDTH-1:0]   rda_nxt;
    logic [WIDTH-1:0]   rdb_nxt;

    onehot_chk u_chk (
        .we    (we),
        .valid (wr_valid),
        .multi (wr_multi),
        .idx   (wr_idx)
    );

    // A valid write to a hardwired-zero register is acknowledged but not stored.
    assign wr_commit = wr_valid && !((ZERO_REG != 0) && (wr_idx == '0));

    function automatic logic [WIDTH-1:0] read_port(input logic [RADDR_W-1:0] addr);
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end else if (wr_valid && (wr_idx == addr)) begin
            return wd;
        end
        return regs[addr];
    endfunction

    always_comb begin
        rda_nxt = read_port(ra);
        rdb_nxt = read_port(rb);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
            rda  <= '0;
            rdb  <= '0;
            wack <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (wr_commit) begin
                regs[wr_idx] <= wd;
            end
            if (!hold) begin
                rda <= rda_nxt;
                rdb <= rdb_nxt;
            end
            wack <= wr_valid;
            // Set has priority over clear on the same edge.
            if (wr_multi) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
